// File: rtl/mem_pkg.sv
// Shared definitions for the data memory unit and its load path.
// Contents:
//   SZ_B/SZ_H/SZ_W/SZ_D  access size encodings (byte, half, word, doubleword)
//   state_t              two-state access FSM (idle / busy)
//   lane_mask()          byte-enable pattern for an access of a given size
//                        starting at a given lane; 8 lanes wide, callers
//                        keep the low N/8 bits.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] offset);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// Request/response bundle between the load/store stage and the data memory.
// master (load/store stage): drives req, we, size, uns, addr, wdata;
//                            receives ready, done, rdata, err.
// slave  (data_mem_unit):    the mirror image.
interface data_mem_unit_if #(parameter int N = 32);
  logic         req;
  logic         we;
  logic [1:0]   size;
  logic         uns;
  logic [N-1:0] addr;
  logic [N-1:0] wdata;
  logic         ready;
  logic         done;
  logic [N-1:0] rdata;
  logic         err;

  modport master (output req, we, size, uns, addr, wdata,
                  input  ready, done, rdata, err);
  modport slave  (input  req, we, size, uns, addr, wdata,
                  output ready, done, rdata, err);
endinterface

// File: rtl/load_align.sv
// Combinational load alignment: moves the addressed byte lanes of a memory
// word down to bit 0 and sign- or zero-extends them to the full width.
// Ports:
//   word    in   N-bit memory word
//   offset  in   byte lane of the access start
//   size    in   access size (SZ_B/SZ_H/SZ_W/SZ_D)
//   uns     in   1 = zero-extend, 0 = sign-extend
//   result  out  aligned, extended load value
module load_align
  import mem_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]            word,
  input  logic [$clog2(N/8)-1:0]  offset,
  input  logic [1:0]              size,
  input  logic                    uns,
  output logic [N-1:0]            result
);

  logic [N-1:0] shifted;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    result  = shifted;
    case (size)
      SZ_B:    result = uns ? N'(shifted[7:0])  : N'($signed(shifted[7:0]));
      SZ_H:    result = uns ? N'(shifted[15:0]) : N'($signed(shifted[15:0]));
      // With N=32 both arms reduce to the full word, so uns has no effect.
      SZ_W:    result = uns ? N'(shifted[31:0]) : N'($signed(shifted[31:0]));
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Byte-addressed data memory with sized loads/stores, error detection and a
// programmable number of wait states behind a req/ready/done handshake.
// Parameters: N data/address width (32 or 64), M depth in words, W wait states.
// Ports:
//   clk  in   clock
//   rst  in   asynchronous active-high reset of all control state
//   bus  slave side of data_mem_unit_if: req/we/size/uns/addr/wdata in,
//        ready/done/rdata/err out
module data_mem_unit
  import mem_pkg::*;
#(
  parameter int N = 32,
  parameter int M = 256,
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_unit_if.slave bus
);

  localparam int NB = N / 8;
  localparam int OW = $clog2(NB);
  localparam int AW = $clog2(M);

  // Contents start at zero and are deliberately untouched by rst.
  logic [N-1:0] mem [M] = '{default: '0};

  state_t       state_reg;
  logic [3:0]   cnt_reg;
  logic         we_reg;
  logic         uns_reg;
  logic [1:0]   size_reg;
  logic [N-1:0] addr_reg;
  logic [N-1:0] wdata_reg;
  logic         done_reg;
  logic         err_reg;
  logic [N-1:0] rdata_reg;

  logic [OW-1:0] offset;
  logic [N-1:0]  word_idx;
  logic [AW-1:0] mem_idx;
  logic [NB-1:0] be;
  logic [N-1:0]  rd_word;
  logic [N-1:0]  wr_data_sh;
  logic [N-1:0]  wr_word;
  logic [N-1:0]  load_result;
  logic          size_bad;
  logic          misaligned;
  logic          out_of_range;
  logic          acc_err;
  logic          execute;

  assign offset       = addr_reg[OW-1:0];
  assign word_idx     = addr_reg >> OW;
  assign mem_idx      = word_idx[AW-1:0];
  assign size_bad     = (size_reg == SZ_D) && (N == 32);
  assign out_of_range = word_idx >= N'(M);
  assign acc_err      = size_bad | misaligned | out_of_range;
  assign execute      = (state_reg == ST_BUSY) && (cnt_reg == 4'd0);
  assign be           = NB'(lane_mask(size_reg, 3'(offset)));
  assign rd_word      = mem[mem_idx];
  assign wr_data_sh   = wdata_reg << {offset, 3'b000};

  always_comb begin
    misaligned = 1'b0;
    case (size_reg)
      SZ_H:    misaligned = addr_reg[0];
      SZ_W:    misaligned = |addr_reg[1:0];
      SZ_D:    misaligned = |addr_reg[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Merge the shifted store data into the current word lane by lane, so a
  // full-word write preserves every lane the access does not address.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign wr_word[gi*8 +: 8] = be[gi] ? wr_data_sh[gi*8 +: 8] : rd_word[gi*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (execute && we_reg && !acc_err) begin
      mem[mem_idx] <= wr_word;
    end
  end

  load_align #(.N(N)) u_load_align (
    .word   (rd_word),
    .offset (offset),
    .size   (size_reg),
    .uns    (uns_reg),
    .result (load_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      we_reg    <= 1'b0;
      uns_reg   <= 1'b0;
      size_reg  <= SZ_B;
      addr_reg  <= '0;
      wdata_reg <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.req) begin
            we_reg    <= bus.we;
            size_reg  <= bus.size;
            uns_reg   <= bus.uns;
            addr_reg  <= bus.addr;
            wdata_reg <= bus.wdata;
            cnt_reg   <= 4'(W);
            state_reg <= ST_BUSY;
          end
        end
        default: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            done_reg  <= 1'b1;
            err_reg   <= acc_err;
            // rdata only moves on a successful load; stores and errors hold it.
            if (!acc_err && !we_reg) begin
              rdata_reg <= load_result;
            end
            state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.ready = (state_reg == ST_IDLE);
  assign bus.done  = done_reg;
  assign bus.err   = err_reg;
  assign bus.rdata = rdata_reg;

endmodule
